// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional parity, stop bit.
// Every serial bit lasts prescale clk cycles (prescale of 0 behaves as 1).
module uart_tx_serializer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] p_data,
  input  logic       data_valid,
  input  logic       par_en,
  input  logic       par_typ,
  input  logic [5:0] prescale,
  output logic       tx_out,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state_r, state_s;
  logic [5:0] cnt_r, cnt_s;
  logic [2:0] idx_r, idx_s;
  logic [2:0] next_idx_s;
  logic [7:0] data_r, data_s;
  logic       par_en_r, par_en_s;
  logic       par_typ_r, par_typ_s;
  logic [5:0] prescale_r, prescale_s;
  logic       tx_r, tx_s;
  logic       busy_r, busy_s;
  logic [5:0] last_cnt_s;
  logic       bit_end_s;

  // Even parity is the XOR of the data bits; odd parity inverts it.
  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Last edge-counter value of a bit period; prescale of 0 is treated as a 1-cycle bit.
  always_comb begin
    last_cnt_s = 6'd0;
    if (prescale_r == 6'd0) begin
      last_cnt_s = 6'd0;
    end else begin
      last_cnt_s = prescale_r - 6'd1;
    end
    bit_end_s  = (cnt_r == last_cnt_s);
    next_idx_s = idx_r + 3'd1;
  end

  // Next-state, next-output and configuration-latch logic.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    data_s     = data_r;
    par_en_s   = par_en_r;
    par_typ_s  = par_typ_r;
    prescale_s = prescale_r;
    tx_s       = tx_r;
    busy_s     = busy_r;
    if (bit_end_s) begin
      cnt_s = 6'd0;
    end else begin
      cnt_s = cnt_r + 6'd1;
    end

    case (state_r)
      IDLE: begin
        cnt_s  = 6'd0;
        idx_s  = 3'd0;
        tx_s   = 1'b1;
        busy_s = 1'b0;
        if (data_valid) begin
          data_s     = p_data;
          par_en_s   = par_en;
          par_typ_s  = par_typ;
          prescale_s = prescale;
          state_s    = START;
          tx_s       = 1'b0;
          busy_s     = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          idx_s   = 3'd0;
          tx_s    = data_r[0];
        end else begin
          tx_s = 1'b0;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          if (idx_r == 3'd7) begin
            idx_s = 3'd0;
            if (par_en_r) begin
              state_s = PARITY;
              tx_s    = parity_bit(data_r, par_typ_r);
            end else begin
              state_s = STOP;
              tx_s    = 1'b1;
            end
          end else begin
            idx_s = next_idx_s;
            tx_s  = data_r[next_idx_s];
          end
        end else begin
          tx_s = data_r[idx_r];
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_s = STOP;
          tx_s    = 1'b1;
        end else begin
          tx_s = parity_bit(data_r, par_typ_r);
        end
      end
      STOP: begin
        tx_s = 1'b1;
        if (bit_end_s) begin
          state_s = IDLE;
          busy_s  = 1'b0;
          cnt_s   = 6'd0;
          idx_s   = 3'd0;
        end else begin
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 6'd0;
        idx_s   = 3'd0;
        tx_s    = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counters, latched frame configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= 6'd0;
      idx_r      <= 3'd0;
      data_r     <= 8'd0;
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      prescale_r <= 6'd0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      idx_r      <= idx_s;
      data_r     <= data_s;
      par_en_r   <= par_en_s;
      par_typ_r  <= par_typ_s;
      prescale_r <= prescale_s;
      tx_r       <= tx_s;
      busy_r     <= busy_s;
    end
  end

  assign tx_out = tx_r;
  assign busy   = busy_r;

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  reset; synchronous, active-low.
- p_data  input  8  parallel byte to transmit.
- data_valid  input  1  p_data is valid; accepted only when idle.
- par_en  input  1  1 = append parity bit.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- prescale  input  6  clk cycles per serial bit.
- tx_out  output  1  serial line; idles high.
- busy  output  1  frame in progress.

REQ-002 tx_out and busy SHALL be driven directly from flops (no combinational path from inputs).

Function
REQ-003 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, and SHALL use no other states.

REQ-004 In IDLE, the block SHALL accept a frame on a rising edge where data_valid=1, and SHALL ignore data_valid in every other state.

REQ-005 At the accept edge, the block SHALL latch p_data, par_en, par_typ and prescale, go to START, and set tx_out<=0 and busy<=1; input changes after accept SHALL NOT affect the frame.

REQ-006 The bit period P SHALL be the latched prescale value, except that prescale=0 SHALL give P=1.

REQ-007 Each serial bit SHALL hold tx_out constant for exactly P clk cycles, timed by a 6-bit edge counter that runs 0..P-1 and wraps to 0 at each bit boundary.

REQ-008 Transmission order SHALL be:
- start bit 0;
- data bits LSB first (bit 0..7), using a 3-bit bit index;
- parity bit, only if the latched par_en=1;
- stop bit 1.

REQ-009 The parity bit SHALL be the XOR of the 8 latched data bits when par_typ=0, and its inversion when par_typ=1.

REQ-010 State transitions SHALL be:
- START -> DATA after P cycles;
- DATA -> PARITY or STOP after bit 7's P cycles;
- PARITY -> STOP after P cycles;
- STOP -> IDLE after P cycles.

REQ-011 At the STOP -> IDLE edge, busy SHALL go to 0 and tx_out SHALL remain 1.

REQ-012 Frame length from accept edge to busy falling SHALL be exactly 10*P clk cycles (par_en=0) or 11*P (par_en=1).

REQ-013 A new frame SHALL be accepted at the earliest on the first edge after busy falls, so the line is high for at least P+1 cycles between frames.

REQ-014 In IDLE, tx_out SHALL be 1 and the edge counter and bit index SHALL hold at 0.

Reset
REQ-015 On a rising edge with reset_n=0, the block SHALL set state=IDLE, tx_out=1, busy=0, and clear the edge counter, bit index and latched data/config to 0.

REQ-016 Reset asserted mid-frame SHALL abort the frame at that edge with no further serial bits.

REQ-017 A data_valid present during reset SHALL be ignored.

REQ-018 Reset SHALL have no effect between clock edges.

Verification
REQ-019 The bench SHALL cover: prescale=8, p_data=0xA5, par_en=0, one-cycle data_valid -> tx_out sequence 0,1,0,1,0,0,1,0,1,1 with each bit 8 cycles; busy high 80 cycles.

REQ-020 The bench SHALL cover: prescale=8, p_data=0xA5, par_en=1, par_typ=0 -> parity bit 0; the same with par_typ=1 -> parity bit 1; busy high 88 cycles.

REQ-021 The bench SHALL cover: prescale=16, p_data=0x01, par_en=1, par_typ=0 -> parity bit 1; frame lasts 176 cycles; data_valid with p_data=0xFF pulsed mid-frame -> ignored, frame unchanged.

REQ-022 The bench SHALL cover: data_valid held high continuously, prescale=4 -> back-to-back frames, each 40 cycles, with exactly one idle-high cycle between consecutive busy periods.

REQ-023 The bench SHALL cover: reset_n=0 for one cycle during data bit 3 -> at that edge tx_out=1, busy=0; the next data_valid starts a clean frame.

REQ-024 The bench SHALL cover: prescale=0 and prescale=1, p_data=0x3C, par_en=0 -> one cycle per bit, busy high 10 cycles; prescale changed mid-frame -> bit timing unchanged.
